// File: rtl/deser_reg.sv
// deser_reg: serial-to-parallel receiver.
// Gathers one bit per sin_valid strobe into a WIDTH-bit shift register and,
// once WIDTH bits have arrived, hands the word to a valid/ready output
// register. A word that completes while the previous one is still unconsumed
// is dropped, and the sticky overflow flag records the loss.
module deser_reg #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin_valid,
    input  logic             sin,
    input  logic             clear,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    input  logic             ovf_clr
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [CW-1:0]    bit_cnt;
    logic             shift_en;
    logic             complete;
    logic             transfer;
    logic             drop;

    // clear takes priority over an incoming bit, so an aborted bit never
    // counts and can never complete a word.
    assign shift_en = sin_valid && !clear;
    assign complete = shift_en && (bit_cnt == LAST_BIT);
    assign transfer = out_valid && out_ready;
    // A finished word is lost only if the holding register is occupied and
    // the consumer is not emptying it on this same edge.
    assign drop     = complete && out_valid && !out_ready;
    assign busy     = (bit_cnt != '0);

    // Shift direction selects the serial bit order.
    generate
        if (MSB_FIRST) begin : g_msb_first
            // First bit received travels up to the top of the word.
            always_comb begin
                shreg_next = {shreg[WIDTH-2:0], sin};
            end
        end else begin : g_lsb_first
            // First bit received travels down to bit 0, mirroring the
            // right-shifting transmitter.
            always_comb begin
                shreg_next = {sin, shreg[WIDTH-1:1]};
            end
        end
    endgenerate

    // Shift register and bit counter; the counter wraps on completion so a
    // new word can start on the very next cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sin_valid) begin
            shreg   <= shreg_next;
            bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
        end
    end

    // Output holding register with valid/ready handshake; a completion that
    // coincides with a transfer simply replaces the outgoing word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (complete && (!out_valid || out_ready)) begin
            out_data  <= shreg_next;
            out_valid <= 1'b1;
        end else if (transfer) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky overflow flag; a new drop beats a simultaneous clear request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
